vga_fb_display: RTL

VGA_FB_DISPLAY -- requirements
Module: vga_fb_display

---
 rtl/vga_fb_display.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_display.sv
// -----------------------------------------------------------------------------
// vga_fb_display
//
// Double-buffered 640x480 VGA framebuffer with an Avalon-MM slave port.
// The CPU writes packed pixels into one of two pages. It requests a page flip
// through CTRL. The flip takes effect at the start of vertical blanking and
// raises a level interrupt. Scan-out is a two-stage pipeline:
// RAM read, then index-to-colour lookup.
//
// Parameters
//   BPP     bits per pixel (1, 2, 4 or 8)
//   ADDR_W  Avalon word-address width; the top bit selects the control region
//
// Ports
//   clk          50 MHz system clock, rising edge
//   reset        synchronous active-high reset
//   chipselect   Avalon slave select
//   write/read   Avalon strobes
//   address      word address (MSB 0 = framebuffer, 1 = control region)
//   writedata    write data
//   readdata     registered read data, valid one clk after read
//   irq          level interrupt, set when a page flip completes
//   VGA_R/G/B    pixel colour
//   VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n   VGA timing
//                (VGA_SYNC_n is tied low)
//
// Build option
//   VGA_FB_PALETTE_EN  when defined, a writable 2^BPP x 24-bit palette maps
//                      pixel indices to colours. When undefined, indices are
//                      shown as grey levels.
// -----------------------------------------------------------------------------
module vga_fb_display #(
  parameter int BPP    = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);

  localparam int PAGE_WORDS = 9600 * BPP;
  localparam int MEM_WORDS  = 2 * PAGE_WORDS;
  localparam int MEM_AW     = $clog2(MEM_WORDS);
  localparam int NUM_COLORS = 1 << BPP;

  localparam logic [31:0] MEM_WORDS_L  = 32'(MEM_WORDS);
  localparam logic [31:0] PAGE_WORDS_L = 32'(PAGE_WORDS);

  // Grey level of a pixel index: the index bit-replicated to 8 bits.
  function automatic logic [7:0] grey_of(input logic [BPP-1:0] idx);
    return {(8 / BPP){idx}};
  endfunction

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;

  // Next raster position: 1600 clks per line, 525 lines per frame.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == 11'd1599) begin
      hcount_d = 11'd0;
      if (vcount_q == 10'd524) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      vcount_d = vcount_q;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q <= 11'd0;
      vcount_q <= 10'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Avalon decode
  // ---------------------------------------------------------------------------
  logic        ctrl_sel_s;
  logic [8:0]  reg_idx_s;
  logic [31:0] fb_off_s;
  logic        fb_we_s;
  logic        ctrl_we_s;
  logic        clr_we_s;
  logic        status_rd_s;

  assign ctrl_sel_s  = chipselect & address[ADDR_W-1];
  assign reg_idx_s   = address[8:0];
  assign fb_off_s    = 32'(address[ADDR_W-2:0]);
  // Writes past the second page are dropped rather than aliased.
  assign fb_we_s     = chipselect & write & ~address[ADDR_W-1] & (fb_off_s < MEM_WORDS_L);
  assign ctrl_we_s   = ctrl_sel_s & write & (reg_idx_s == 9'h000);
  assign clr_we_s    = ctrl_sel_s & write & (reg_idx_s == 9'h002);
  assign status_rd_s = ctrl_sel_s & read & (reg_idx_s == 9'h001);

  // ---------------------------------------------------------------------------
  // Page flip control and read data
  // ---------------------------------------------------------------------------
  logic        disp_page_q, disp_page_d;
  logic        req_page_q, req_page_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;
  logic        flip_s;

  // Flip happens at the first clk of vertical blanking, so a page never
  // changes while active pixels are being fetched.
  assign flip_s = pending_q & (hcount_q == 11'd0) & (vcount_q == 10'd480);

  // Control next state. The flip consumes the old request before a
  // same-cycle CTRL write re-arms it. A flip overrides a same-cycle IRQ_CLR.
  always_comb begin
    disp_page_d = disp_page_q;
    req_page_d  = req_page_q;
    pending_d   = pending_q;
    irq_d       = irq_q;
    readdata_d  = 32'd0;
    if (flip_s) begin
      disp_page_d = req_page_q;
      pending_d   = 1'b0;
    end else begin
      disp_page_d = disp_page_q;
    end
    if (ctrl_we_s) begin
      req_page_d = writedata[0];
      pending_d  = 1'b1;
    end else begin
      req_page_d = req_page_q;
    end
    if (flip_s) begin
      irq_d = 1'b1;
    end else if (clr_we_s) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
    if (status_rd_s) begin
      readdata_d = {29'd0, irq_q, pending_q, disp_page_q};
    end else begin
      readdata_d = 32'd0;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_page_q <= 1'b0;
      req_page_q  <= 1'b0;
      pending_q   <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      disp_page_q <= disp_page_d;
      req_page_q  <= req_page_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-out address
  // ---------------------------------------------------------------------------
  logic              active_s;
  logic [18:0]       pix_s;
  logic [22:0]       bitpos_s;
  logic [31:0]       page_base_s;
  logic [MEM_AW-1:0] rd_addr_s;

  assign active_s = (hcount_q < 11'd1280) & (vcount_q < 10'd480);

  // Linear pixel number, its bit position, and the word that holds it.
  // Outside the active area the address is parked at 0 to stay in range.
  always_comb begin
    pix_s       = 19'(vcount_q) * 19'd640 + 19'(hcount_q[10:1]);
    bitpos_s    = 23'(pix_s) * 23'(BPP);
    page_base_s = disp_page_q ? PAGE_WORDS_L : 32'd0;
    if (active_s) begin
      rd_addr_s = MEM_AW'(page_base_s + 32'(bitpos_s >> 5));
    end else begin
      rd_addr_s = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: framebuffer RAM (contents survive reset) and timing delay
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] mem_word_q;
  logic [4:0]  field_off_q;
  logic        hs1_q, vs1_q, blank1_q, pclk1_q;

  // Framebuffer storage: CPU write port and scan-out read port.
  always_ff @(posedge clk) begin
    if (fb_we_s) begin
      mem_q[fb_off_s[MEM_AW-1:0]] <= writedata;
    end
    mem_word_q <= mem_q[rd_addr_s];
  end

  // Stage-1 timing and field offset, aligned with the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      field_off_q <= 5'd0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      blank1_q    <= 1'b0;
      pclk1_q     <= 1'b0;
    end else begin
      field_off_q <= bitpos_s[4:0];
      hs1_q       <= ~((hcount_q >= 11'd1312) & (hcount_q <= 11'd1503));
      vs1_q       <= ~((vcount_q == 10'd490) | (vcount_q == 10'd491));
      blank1_q    <= active_s;
      pclk1_q     <= hcount_q[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: index extraction and colour lookup
  // ---------------------------------------------------------------------------
  logic [31:0]    shifted_s;
  logic [BPP-1:0] idx_s;
  logic [23:0]    colour_s;
  logic [23:0]    rgb_q;
  logic           hs2_q, vs2_q, blank2_q, pclk2_q;

  assign shifted_s = mem_word_q >> field_off_q;
  assign idx_s     = shifted_s[BPP-1:0];

`ifdef VGA_FB_PALETTE_EN
  logic [23:0] palette_q [NUM_COLORS];
  logic        pal_we_s;

  // Only entries that a BPP-bit index can reach are writable.
  assign pal_we_s = ctrl_sel_s & write & reg_idx_s[8]
                  & ({1'b0, reg_idx_s[7:0]} < 9'(NUM_COLORS));

  // Palette register file, reset to the grey ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        palette_q[i] <= {3{grey_of(BPP'(i))}};
      end
    end else if (pal_we_s) begin
      palette_q[reg_idx_s[BPP-1:0]] <= writedata[23:0];
    end
  end

  // Colour from the palette.
  always_comb begin
    colour_s = palette_q[idx_s];
  end
`else
  // Colour is the grey level of the index.
  always_comb begin
    colour_s = {3{grey_of(idx_s)}};
  end
`endif

  // Output registers; colour is forced to black during blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q    <= 24'd0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      pclk2_q  <= 1'b0;
    end else begin
      rgb_q    <= blank1_q ? colour_s : 24'd0;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      blank2_q <= blank1_q;
      pclk2_q  <= pclk1_q;
    end
  end

  // Bits that are intentionally not consumed in this build.
  logic unused_s;
`ifdef VGA_FB_PALETTE_EN
  assign unused_s = ^{writedata[31:24], shifted_s[31:BPP]};
`else
  assign unused_s = ^{writedata[31:1], shifted_s[31:BPP]};
`endif

  assign readdata    = readdata_q;
  assign irq         = irq_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_n = blank2_q;
  assign VGA_CLK     = pclk2_q;
  assign VGA_SYNC_n  = 1'b0;

endmodule
